// File: rtl/mcu_pkg.sv
// Shared types for the multi-cycle controller: opcodes, state encoding, control payload.
// Build option: MCU_JUMP_EN adds the JMP opcode and the JUMP state decode.
package mcu_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned CNT_W    = 16;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b110101;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 6'b010000;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pc_source_e;

    // Moore portion of the datapath controls; FETCH-time IR/PC loads are gated separately.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_source_e pc_source;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcu_if.sv
// Controller <-> IR/datapath bundle; master is the controller, slave the datapath side.
interface mcu_if;
    import mcu_pkg::*;

    logic [OPCODE_W-1:0] instr_op_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                pc_write_cond_o;
    logic                i_or_d_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                ir_write_o;
    logic                mem_to_reg_o;
    logic                reg_dst_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [1:0]          pc_source_o;
    logic                illegal_op_o;
    logic                mem_timeout_o;
    logic [CNT_W-1:0]    retired_cnt_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               pc_source_o, illegal_op_o, mem_timeout_o, retired_cnt_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               pc_source_o, illegal_op_o, mem_timeout_o, retired_cnt_o
    );

endinterface

// File: rtl/mcu_wait_timer.sv
// Saturating count of consecutive not-ready cycles; expired flags the abort cycle.
module mcu_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // This cycle would be the LIMIT-th consecutive wait.
    assign expired_o = inc_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle datapath with memory-wait timeout and retire counter.
// Build option: MCU_JUMP_EN decodes JMP into a single-cycle JUMP state.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic clk,
    input logic rst_n,
    mcu_if.master bus_io
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             retire_c;
    logic             illegal_c;
    logic             timeout_c;
    logic             wait_inc;
    logic             wait_clr;
    logic             expired;
    logic             fetch_ready;

    assign wait_inc = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                      && !bus_io.mem_ready_i;
    assign wait_clr = (state_d != state_q) || timeout_c;

    mcu_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wait_clr),
        .inc_i     (wait_inc),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (bus_io.mem_ready_i) state_d = S_DECODE;
                else if (expired)       timeout_c = 1'b1;
            end
            S_DECODE: begin
                case (bus_io.instr_op_i)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MCU_JUMP_EN
                    OP_JMP:       state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (bus_io.instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus_io.mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (expired) begin
                    state_d   = S_FETCH;
                    timeout_c = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (bus_io.mem_ready_i) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end else if (expired) begin
                    state_d   = S_FETCH;
                    timeout_c = 1'b1;
                end
            end
            S_EXEC: state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
`endif
            default: state_d = S_RST;
        endcase
    end

    // Controls are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            ctrl_q        <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
            if (retire_c) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
        end
    end

    assign fetch_ready = (state_q == S_FETCH) && bus_io.mem_ready_i;

    assign bus_io.pc_write_o      = ctrl_q.pc_write | fetch_ready;
    assign bus_io.ir_write_o      = fetch_ready;
    assign bus_io.pc_write_cond_o = ctrl_q.pc_write_cond;
    assign bus_io.i_or_d_o        = ctrl_q.i_or_d;
    assign bus_io.mem_read_o      = ctrl_q.mem_read;
    assign bus_io.mem_write_o     = ctrl_q.mem_write;
    assign bus_io.mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign bus_io.reg_dst_o       = ctrl_q.reg_dst;
    assign bus_io.reg_write_o     = ctrl_q.reg_write;
    assign bus_io.alu_src_a_o     = ctrl_q.alu_src_a;
    assign bus_io.alu_src_b_o     = ctrl_q.alu_src_b;
    assign bus_io.alu_op_o        = ctrl_q.alu_op;
    assign bus_io.pc_source_o     = ctrl_q.pc_source;
    assign bus_io.illegal_op_o    = illegal_c;
    assign bus_io.mem_timeout_o   = timeout_c;
    assign bus_io.retired_cnt_o   = retired_cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed spec scenarios plus random instruction stream.
module tb_multicycle_control_unit;
    import mcu_pkg::*;

    localparam int unsigned TMO = 4;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_MADDR  = 2;
    localparam int PH_MRD    = 3;
    localparam int PH_MWB    = 4;
    localparam int PH_MWR    = 5;
    localparam int PH_EXEC   = 6;
    localparam int PH_ALUWB  = 7;
    localparam int PH_BRANCH = 8;
    localparam int PH_JUMP   = 9;
    localparam int PH_IDLE   = 10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_timeout;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [CNT_W-1:0] cnt_exp;

    mcu_if bus ();

    multicycle_control_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.pc_write      = bus.pc_write_o;
        o.pc_write_cond = bus.pc_write_cond_o;
        o.i_or_d        = bus.i_or_d_o;
        o.mem_read      = bus.mem_read_o;
        o.mem_write     = bus.mem_write_o;
        o.ir_write      = bus.ir_write_o;
        o.mem_to_reg    = bus.mem_to_reg_o;
        o.reg_dst       = bus.reg_dst_o;
        o.reg_write     = bus.reg_write_o;
        o.alu_src_a     = bus.alu_src_a_o;
        o.alu_src_b     = bus.alu_src_b_o;
        o.alu_op        = bus.alu_op_o;
        o.pc_source     = bus.pc_source_o;
        o.illegal_op    = bus.illegal_op_o;
        o.mem_timeout   = bus.mem_timeout_o;
        return o;
    endfunction

    // Expected control word for one cycle of a given instruction phase.
    function automatic out_t phase_out(input int ph, input bit rdy, input bit tmo, input bit ill);
        out_t e;
        e = '0;
        case (ph)
            PH_FETCH: begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = rdy;  e.pc_write = rdy;
            end
            PH_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            PH_MADDR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            PH_MRD:    begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
            PH_MWB:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            PH_MWR:    begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
            PH_EXEC:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b10; end
            PH_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            PH_BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                e.pc_write_cond = 1'b1; e.pc_source = 2'b01;
            end
            PH_JUMP:   begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
            default: ;
        endcase
        e.mem_timeout = tmo;
        return e;
    endfunction

    function automatic bit legal(input logic [OPCODE_W-1:0] op);
`ifdef MCU_JUMP_EN
        return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_JMP;
`else
        return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ;
`endif
    endfunction

    task automatic step(input out_t e, input string tag);
        out_t o;
        @(negedge clk);
        o = sample();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, o, e);
        end
        total++;
        assert (bus.retired_cnt_o === cnt_exp) else begin
            bad++;
            $error("FAIL %s retired_cnt observed=%0d expected=%0d", tag, bus.retired_cnt_o, cnt_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ready();
        bus.mem_ready_i = 1'($urandom);
    endtask

    // Drives `waits` not-ready cycles in a memory phase; aborts on the TMO-th one.
    task automatic wait_phase(input int ph, input int waits, input string tag, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < waits; i++) begin
            bus.mem_ready_i = 1'b0;
            if (i == int'(TMO) - 1) begin
                step(phase_out(ph, 1'b0, 1'b1, 1'b0), {tag, "_timeout"});
                aborted = 1'b1;
                return;
            end
            step(phase_out(ph, 1'b0, 1'b0, 1'b0), {tag, "_wait"});
        end
    endtask

    task automatic run_instr(input logic [OPCODE_W-1:0] op, input int fw, input int mw);
        bit ab;
        bus.instr_op_i = OPCODE_W'($urandom);
        wait_phase(PH_FETCH, fw, "fetch", ab);
        if (ab) return;
        bus.mem_ready_i = 1'b1;
        step(phase_out(PH_FETCH, 1'b1, 1'b0, 1'b0), "fetch");
        bus.instr_op_i = op;
        rand_ready();
        if (!legal(op)) begin
            step(phase_out(PH_DECODE, 1'b0, 1'b0, 1'b1), "decode_illegal");
            return;
        end
        step(phase_out(PH_DECODE, 1'b0, 1'b0, 1'b0), "decode");
        rand_ready();
        if (op == OP_RTYPE) begin
            step(phase_out(PH_EXEC, 1'b0, 1'b0, 1'b0), "exec");
            rand_ready();
            step(phase_out(PH_ALUWB, 1'b0, 1'b0, 1'b0), "alu_wb");
            cnt_exp++;
        end else if (op == OP_LW) begin
            step(phase_out(PH_MADDR, 1'b0, 1'b0, 1'b0), "lw_addr");
            wait_phase(PH_MRD, mw, "mem_rd", ab);
            if (ab) return;
            bus.mem_ready_i = 1'b1;
            step(phase_out(PH_MRD, 1'b1, 1'b0, 1'b0), "mem_rd");
            rand_ready();
            step(phase_out(PH_MWB, 1'b0, 1'b0, 1'b0), "mem_wb");
            cnt_exp++;
        end else if (op == OP_SW) begin
            step(phase_out(PH_MADDR, 1'b0, 1'b0, 1'b0), "sw_addr");
            wait_phase(PH_MWR, mw, "mem_wr", ab);
            if (ab) return;
            bus.mem_ready_i = 1'b1;
            step(phase_out(PH_MWR, 1'b1, 1'b0, 1'b0), "mem_wr");
            cnt_exp++;
        end else if (op == OP_BEQ) begin
            step(phase_out(PH_BRANCH, 1'b0, 1'b0, 1'b0), "branch");
            cnt_exp++;
        end else begin
            step(phase_out(PH_JUMP, 1'b0, 1'b0, 1'b0), "jump");
            cnt_exp++;
        end
    endtask

    initial begin
        logic [OPCODE_W-1:0] op;
        int                  sel;
        out_t                o;

        rst_n           = 1'b0;
        bus.mem_ready_i = 1'b0;
        bus.instr_op_i  = '0;
        cnt_exp         = '0;

        // Reset state, then the single RST cycle after release.
        step(phase_out(PH_IDLE, 1'b0, 1'b0, 1'b0), "in_reset");
        rst_n = 1'b1;
        rand_ready();
        step(phase_out(PH_IDLE, 1'b0, 1'b0, 1'b0), "rst_state");

        // Directed scenarios.
        run_instr(OP_LW, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_LW, 0, int'(TMO));
        run_instr(OP_SW, 1, int'(TMO));
        run_instr(OP_RTYPE, int'(TMO), 0);
        run_instr(OP_JMP, 0, 0);
        run_instr(6'b111111, 2, 0);
        run_instr(OP_LW, int'(TMO) - 1, int'(TMO) - 1);

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_JMP;
                default: op = OPCODE_W'($urandom);
            endcase
            run_instr(op,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO, TMO + 1)) : int'($urandom_range(0, 2)),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO, TMO + 1)) : int'($urandom_range(0, TMO - 1)));
        end

        // Reset asserted while in EXEC: outputs must drop without a clock edge.
        bus.mem_ready_i = 1'b1;
        step(phase_out(PH_FETCH, 1'b1, 1'b0, 1'b0), "pre_rst_fetch");
        bus.instr_op_i = OP_RTYPE;
        step(phase_out(PH_DECODE, 1'b0, 1'b0, 1'b0), "pre_rst_decode");
        rst_n = 1'b0;
        #1;
        o = sample();
        total++;
        assert (o === out_t'('0)) else begin
            bad++;
            $error("FAIL async_rst ctrl observed=%h expected=%h", o, out_t'('0));
        end
        cnt_exp = '0;
        total++;
        assert (bus.retired_cnt_o === cnt_exp) else begin
            bad++;
            $error("FAIL async_rst retired_cnt observed=%0d expected=%0d", bus.retired_cnt_o, cnt_exp);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(phase_out(PH_IDLE, 1'b0, 1'b0, 1'b0), "post_rst_state");
        run_instr(OP_BEQ, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
